// File: rtl/vector_field_arbiter.sv
// vector_field_arbiter
// Two-requester round-robin front end that shares one registered bit-field
// extraction datapath (bit select, nibble slice, bit reversal) and returns a
// tagged result over a valid/ready response channel.
module vector_field_arbiter #(
   parameter int CNT_W      = 16,
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [7:0]       req_data0,
   input  logic [1:0]       req_op0,
   input  logic [2:0]       req_sel0,
   input  logic [7:0]       req_data1,
   input  logic [1:0]       req_op1,
   input  logic [2:0]       req_sel1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_id,
   output logic             rsp_err,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic             prio_q;
   logic             gnt_id_q;
   logic [7:0]       data_q;
   logic [1:0]       op_q;
   logic [2:0]       sel_q;
   logic [7:0]       rsp_data_q;
   logic             rsp_id_q;
   logic             rsp_err_q;
   logic             rsp_valid_q;
   logic [CNT_W-1:0] done_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] done_cnt_d;
   logic [CNT_W-1:0] err_cnt_d;

   logic             grantAny;
   logic             grantIdx;
   logic [7:0]       selData;
   logic [1:0]       selOp;
   logic [2:0]       selSel;
   logic [7:0]       fieldData;
   logic             fieldErr;

   // Pick the winner: a lone requester always wins, a contested cycle goes to
   // the priority pointer; operands come only from the winner so the loser's
   // inputs (possibly X) never reach the capture registers.
   always_comb begin
      grantAny = |req_valid;
      grantIdx = 1'b0;
      case (req_valid)
         2'b01:   grantIdx = 1'b0;
         2'b10:   grantIdx = 1'b1;
         2'b11:   grantIdx = prio_q;
         default: grantIdx = 1'b0;
      endcase
      selData = grantIdx ? req_data1 : req_data0;
      selOp   = grantIdx ? req_op1   : req_op0;
      selSel  = grantIdx ? req_sel1  : req_sel0;
      req_ready = 2'b00;
      if (state_q == IDLE && !rst && grantAny) begin
         req_ready[grantIdx] = 1'b1;
      end
   end

   // Field extraction on the captured operands; illegal opcode yields zero data.
   always_comb begin
      fieldData = 8'h00;
      fieldErr  = 1'b0;
      case (op_q)
         2'b00: fieldData = {7'b0, data_q[sel_q]};
         2'b01: fieldData = sel_q[0] ? {4'b0, data_q[7:4]} : {4'b0, data_q[3:0]};
         2'b10: begin
            for (int i = 0; i < 8; i++) begin
               fieldData[i] = data_q[7-i];
            end
         end
         default: fieldErr = 1'b1;
      endcase
   end

   // Saturating next values for the completion and error counters.
   always_comb begin
      done_cnt_d = (done_cnt_q == '1) ? done_cnt_q : done_cnt_q + 1'b1;
      err_cnt_d  = (rsp_err_q && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
   end

   // Sequencer: grant and capture in IDLE, compute in EXEC, hold the result
   // in RESP until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= FIRST_PRIO;
         gnt_id_q    <= 1'b0;
         data_q      <= 8'h00;
         op_q        <= 2'b00;
         sel_q       <= 3'b000;
         rsp_data_q  <= 8'h00;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         done_cnt_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantAny) begin
                  gnt_id_q <= grantIdx;
                  data_q   <= selData;
                  op_q     <= selOp;
                  sel_q    <= selSel;
                  prio_q   <= ~grantIdx;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q  <= fieldData;
               rsp_err_q   <= fieldErr;
               rsp_id_q    <= gnt_id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  done_cnt_q  <= done_cnt_d;
                  err_cnt_q   <= err_cnt_d;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;
   assign done_cnt  = done_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_vector_field_arbiter.sv
// tb_vector_field_arbiter
// Directed bench for vector_field_arbiter with a transaction-level reference
// model checked every cycle, plus literal expectations from worked examples.
module tb_vector_field_arbiter;

   localparam int CNT_W = 3;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [7:0]       req_data0;
   logic [1:0]       req_op0;
   logic [2:0]       req_sel0;
   logic [7:0]       req_data1;
   logic [1:0]       req_op1;
   logic [2:0]       req_sel1;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;
   logic             rsp_id;
   logic             rsp_err;
   logic [CNT_W-1:0] done_cnt;
   logic [CNT_W-1:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   vector_field_arbiter #(.CNT_W(CNT_W), .FIRST_PRIO(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data0 (req_data0),
      .req_op0   (req_op0),
      .req_sel0  (req_sel0),
      .req_data1 (req_data1),
      .req_op1   (req_op1),
      .req_sel1  (req_sel1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .done_cnt  (done_cnt),
      .err_cnt   (err_cnt)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected field as {err, data}, written straight from the operation rules.
   function automatic logic [8:0] fieldOf(input logic [7:0] d, input logic [1:0] op, input logic [2:0] sel);
      logic [8:0] r;
      r = 9'h000;
      case (op)
         2'b00: r = {1'b0, 8'((d >> sel) & 8'h01)};
         2'b01: r = {1'b0, sel[0] ? 8'(d / 16) : 8'(d % 16)};
         2'b10: r = {1'b0, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
         default: r = {1'b1, 8'h00};
      endcase
      return r;
   endfunction

   function automatic logic [1:0] grantMask(input logic [1:0] v, input bit ptr);
      if (v == 2'b01) return 2'b01;
      if (v == 2'b10) return 2'b10;
      if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   // Reference model: phase 0 waiting, 1 computing, 2 presenting a result.
   int         mPhase = 0;
   bit         mPtr   = 1'b0;
   logic [7:0] mData  = 8'h00;
   bit         mId    = 1'b0;
   bit         mErr   = 1'b0;
   int         mDone  = 0;
   int         mErrs  = 0;
   logic [1:0] mMask;
   logic [8:0] mRes;

   // Advance the model on each clock edge or reset assertion.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPhase = 0;
         mPtr   = 1'b0;
         mErr   = 1'b0;
         mDone  = 0;
         mErrs  = 0;
      end else begin
         case (mPhase)
            0: begin
               mMask = grantMask(req_valid, mPtr);
               if (mMask != 2'b00) begin
                  mId    = mMask[1];
                  mRes   = mId ? fieldOf(req_data1, req_op1, req_sel1) : fieldOf(req_data0, req_op0, req_sel0);
                  mErr   = mRes[8];
                  mData  = mRes[7:0];
                  mPtr   = !mId;
                  mPhase = 1;
               end
            end
            1: mPhase = 2;
            default: begin
               if (rsp_ready) begin
                  if (mDone < MAXC) mDone++;
                  if (mErr && mErrs < MAXC) mErrs++;
                  mErr   = 1'b0;
                  mPhase = 0;
               end
            end
         endcase
      end
   end

   // Compare every DUT output against the model in the middle of each cycle.
   always @(negedge clk) begin
      checkOutput("req_ready", req_ready, (!rst && mPhase == 0) ? grantMask(req_valid, mPtr) : 2'b00);
      checkOutput("rsp_valid", rsp_valid, (mPhase == 2) ? 1 : 0);
      checkOutput("rsp_err", rsp_err, (mPhase == 2) ? mErr : 1'b0);
      if (mPhase == 2) begin
         checkOutput("rsp_data", rsp_data, mData);
         checkOutput("rsp_id", rsp_id, mId);
      end
      checkOutput("done_cnt", done_cnt, mDone);
      checkOutput("err_cnt", err_cnt, mErrs);
   end

   task automatic startReq(input int idx, input logic [7:0] d, input logic [1:0] op, input logic [2:0] sel);
      if (idx == 0) begin
         req_data0 = d; req_op0 = op; req_sel0 = sel;
      end else begin
         req_data1 = d; req_op1 = op; req_sel1 = sel;
      end
      req_valid[idx] = 1'b1;
   endtask

   task automatic waitGrant(input int idx, input bit drop);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("grant_wait", ok, 1);
      @(posedge clk);
      #1;
      if (drop) begin
         req_valid[idx] = 1'b0;
         if (idx == 0) req_data0 = 8'($urandom); else req_data1 = 8'($urandom);
      end
   endtask

   task automatic waitRsp(input string nm, input logic [7:0] d, input bit id, input bit err);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({nm, "_valid"}, ok, 1);
      checkOutput({nm, "_data"}, rsp_data, d);
      checkOutput({nm, "_id"}, rsp_id, id);
      checkOutput({nm, "_err"}, rsp_err, err);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input string nm, input int idx, input logic [7:0] d, input logic [1:0] op,
                                input logic [2:0] sel, input logic [7:0] expD, input bit expErr);
      startReq(idx, d, op, sel);
      waitGrant(idx, 1'b1);
      @(negedge clk);
      checkOutput({nm, "_exec_quiet"}, rsp_valid, 0);
      waitRsp(nm, expD, idx[0], expErr);
   endtask

   // Bound the whole run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
      req_data0 = 8'h00; req_op0 = 2'b00; req_sel0 = 3'd0;
      req_data1 = 8'h00; req_op1 = 2'b00; req_sel1 = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_data", rsp_data, 0);
      checkOutput("reset_rsp_id", rsp_id, 0);
      checkOutput("reset_rsp_err", rsp_err, 0);
      checkOutput("reset_done", done_cnt, 0);
      checkOutput("reset_err", err_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Contention from reset: grants alternate starting at requester 0.
      req_data0 = 8'h81; req_op0 = 2'b00; req_sel0 = 3'd0;
      req_data1 = 8'hF0; req_op1 = 2'b10; req_sel1 = 3'd0;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         waitRsp("contend", (k % 2 == 1) ? 8'h0F : 8'h01, k[0], 1'b0);
      end
      req_valid = 2'b00;
      checkOutput("done_after_contend", done_cnt, 4);

      // Single-request reversal, bit select and nibble slices.
      applyStimulus("reverse_a5", 0, 8'hA5, 2'b10, 3'd0, 8'hA5, 1'b0);
      checkOutput("done_after_single", done_cnt, 5);
      applyStimulus("bitsel", 1, 8'h3C, 2'b00, 3'd2, 8'h01, 1'b0);
      applyStimulus("nib_hi", 1, 8'h3C, 2'b01, 3'd1, 8'h03, 1'b0);
      applyStimulus("nib_lo", 1, 8'h3C, 2'b01, 3'd0, 8'h0C, 1'b0);
      checkOutput("done_saturated", done_cnt, 7);

      // Illegal opcode.
      applyStimulus("illegal", 0, 8'hFF, 2'b11, 3'd0, 8'h00, 1'b1);
      checkOutput("err_after_illegal", err_cnt, 1);
      checkOutput("done_stays_sat", done_cnt, 7);

      // Back-pressure: result held while the other requester waits.
      rsp_ready = 1'b0;
      startReq(0, 8'h01, 2'b10, 3'd0);
      waitGrant(0, 1'b1);
      waitRsp("stall_first", 8'h80, 1'b0, 1'b0);
      startReq(1, 8'hF0, 2'b01, 3'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", rsp_valid, 1);
         checkOutput("stall_data", rsp_data, 8'h80);
         checkOutput("stall_ready", req_ready, 2'b00);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall_release_valid", rsp_valid, 1);
      @(negedge clk);
      checkOutput("grant_after_stall", req_ready, 2'b10);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      waitRsp("after_stall", 8'h0F, 1'b1, 1'b0);

      // Error counter saturation.
      for (int k = 0; k < 7; k++) begin
         applyStimulus("illegal_loop", k % 2, 8'($urandom), 2'b11, 3'($urandom), 8'h00, 1'b1);
      end
      checkOutput("err_saturated", err_cnt, 7);
      checkOutput("done_saturated_end", done_cnt, 7);

      // Async reset while computing aborts; held request is granted again.
      startReq(0, 8'hA5, 2'b01, 3'd0);
      waitGrant(0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_rsp_valid", rsp_valid, 0);
      checkOutput("abort_done", done_cnt, 0);
      checkOutput("abort_err", err_cnt, 0);
      checkOutput("abort_ready", req_ready, 2'b00);
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      checkOutput("regrant", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      waitRsp("after_reset", 8'h05, 1'b0, 1'b0);
      checkOutput("done_after_reset", done_cnt, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_field_arbiter.md
Name: vector_field_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered bit-field extraction datapath between two requesters. The datapath supports single-bit select, nibble slice and bit-order reversal on an 8-bit word. Each requester submits a word plus an opcode over a valid/ready handshake. The block grants one request at a time, computes the field, and returns a tagged result over a valid/ready response channel.

Parameters:
CNT_W, 16, width of the completed-transaction and error counters (saturating).
FIRST_PRIO, 0, requester (0 or 1) that wins the first contested arbitration after reset.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  2  bit i: requester i has a request pending.
req_ready  output  2  bit i: request i accepted this cycle.
req_data0  input  8  requester 0 operand word.
req_op0  input  2  requester 0 opcode.
req_sel0  input  3  requester 0 bit index / nibble select.
req_data1  input  8  requester 1 operand word.
req_op1  input  2  requester 1 opcode.
req_sel1  input  3  requester 1 bit index / nibble select.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_data  output  8  extracted field.
rsp_id  output  1  requester that owns rsp_data.
rsp_err  output  1  opcode was illegal.
done_cnt  output  CNT_W  completed responses, saturating at all-ones.
err_cnt  output  CNT_W  completed responses with rsp_err=1, saturating.

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; done_cnt=0; err_cnt=0; priority pointer=FIRST_PRIO.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if no req_valid, stay. If exactly one is set, grant it. If both are set, grant the requester at the priority pointer.
  - req_ready[grant]=1 combinationally for that cycle only. Operands are captured at the edge. Next state is EXEC.
  - The pointer moves to the non-granted requester. It updates on every grant, including uncontested ones.
- EXEC, one cycle, register the result:
  - op=00: rsp_data={7'b0, data[sel]}.
  - op=01: sel[0]=1 gives {4'b0, data[7:4]}; sel[0]=0 gives {4'b0, data[3:0]}; sel[2:1] is ignored.
  - op=10: rsp_data[i]=data[7-i] for i=0..7 (bit reversal).
  - op=11: rsp_data=8'h00, rsp_err=1.
  - rsp_id=granted index. Next state is RESP.
- RESP: rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until the handshake.
  - On rsp_valid&&rsp_ready: done_cnt+1, and err_cnt+1 if rsp_err. Both saturate.
  - Then go to IDLE; rsp_valid drops next cycle, and rsp_err clears to 0 there.
- Latency: grant edge to rsp_valid high is 2 cycles. Minimum of 3 cycles per transaction. req_ready is 0 in EXEC and RESP.
- A requester holds its valid and operands until its req_ready. Dropping valid before grant withdraws the request; this is legal.
- rsp_ready held high in RESP completes the handshake in the first RESP cycle. Back-pressure stalls the FSM indefinitely with no loss.
- Asserting rst mid-transaction aborts it: no response is issued and counters clear.
- req_valid with X or unselected inputs must not affect the operands of the granted requester.

Test Plan:
- Single request: req_valid=01, data0=8'hA5, op0=10 -> req_ready=01 for one cycle; 2 cycles later rsp_valid=1, rsp_data=8'hA5 (reversed 10100101 = 10100101), rsp_id=0; done_cnt=1 after the handshake.
- Bit select and nibble: data1=8'h3C, op1=00, sel1=2 -> rsp_data=8'h01, id=1; then op1=01, sel1=1 -> rsp_data=8'h03; sel1=0 -> 8'h0C.
- Contention: both valid held continuously, FIRST_PRIO=0 -> grants alternate 0,1,0,1 over 4 transactions; rsp_id sequence 0,1,0,1.
- Illegal op: op0=11, data0=8'hFF -> rsp_data=8'h00, rsp_err=1; err_cnt=1 and done_cnt=1 after the handshake.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready stays 00; rsp_ready=1 completes the handshake and the next grant follows in IDLE.
- Async reset in EXEC: assert rst mid-cycle -> rsp_valid=0 and counters 0 immediately, state IDLE; the aborted request is re-granted only if still valid after reset release.
